imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time loader upstream of the single-cycle CPU core. It receives a byte stream
//  (length header + big-endian 32-bit words), writes the words into instruction memory
//  starting at word 0, and holds the core in reset (CpuHold=1) until the image is loaded.
//  The core fetches only after CpuHold falls.
// PARAMETERS
//  ADDR_W   10   instruction-memory word-address width; capacity 2**ADDR_W words (1..16)
// PORTS
//  Clk        in   1       system clock, rising edge
//  Reset      in   1       asynchronous, active-low reset
//  start      in   1       pulse: begin a load (honoured in IDLE, DONE, ERR only)
//  in_valid   in   1       byte-stream valid
//  in_data    in   8       byte-stream data
//  in_ready   out  1       loader accepts a byte; transfer = in_valid & in_ready
//  im_we      out  1       IM write strobe, one cycle per word
//  im_addr    out  ADDR_W  IM word address
//  im_wdata   out  32      IM write data
//  CpuHold    out  1       1 = keep CPU in reset; drives the core's reset input
//  done       out  1       image loaded, level
//  error      out  1       load aborted, level
// BEHAVIOUR
//  - Reset=0 (any time, including mid-load): state IDLE. in_ready=0, im_we=0, im_addr=0,
//    im_wdata=0, CpuHold=1, done=0, error=0, counters and checksum cleared.
//  - States: IDLE, LEN_HI, LEN_LO, DATA, CSUM (macro only), DONE, ERR.
//  - IDLE/DONE/ERR --start--> LEN_HI. This clears done/error, sets CpuHold=1 and
//    resets the word counter. start in any other state is ignored.
//  - in_ready=1 only in LEN_HI, LEN_LO, DATA and CSUM. It is registered, so it
//    changes on the edge after a state change.
//  - LEN_HI, LEN_LO: accepted bytes form the 16-bit word count N (MSB first).
//    On the LEN_LO byte:
//      N=0            -> DONE (or CSUM when enabled)
//      N > 2**ADDR_W  -> ERR
//      otherwise      -> DATA
//  - DATA: bytes are packed MSB first. On the 4th byte, the next cycle drives
//    im_we=1, im_addr=word index, im_wdata=word. Streaming is not stalled,
//    giving 1 word per 4 accepted bytes. After word N-1 is written:
//    -> DONE (or CSUM).
//  - im_we is asserted exactly N times. Address increments 0..N-1 with no wrap
//    (the bound is checked at the header). im_addr/im_wdata hold their last value
//    when im_we=0.
//  - DONE: CpuHold=0 and done=1 from the cycle after the final im_we. These hold
//    until reset or start.
//  - ERR: CpuHold=1, error=1, in_ready=0. Exit only via start or reset.
//  - A byte presented while in_ready=0 is not consumed. The source must hold it.
// CONFIGURATION
//  - LOADER_CHECKSUM_EN defined: after the payload, CSUM accepts one byte. It must
//    equal the XOR of all header and payload bytes.
//      match    -> DONE
//      mismatch -> ERR (IM contents are already written; CpuHold stays 1)
//  - LOADER_CHECKSUM_EN undefined: no CSUM state and no checksum logic. The
//    transition goes directly to DONE.
// STRUCTURE
//  - Package loader_pkg:
//      state enum loader_state_t
//      LEN_BYTES=2
//      WORD_BYTES=4
//      helper function word_limit(ADDR_W)
//  - Sub-module byte_packer: 2-bit byte counter plus 32-bit shift register.
//    It flags word_valid for one cycle when a word completes and is cleared on start.
//  - FSM, counters, checksum and output registers live in imem_loader.
// TESTING
//  1. Reset low mid-DATA (after 6 bytes)
//     -> next cycle: CpuHold=1, in_ready=0, im_we=0, done=0.
//     Start again: load completes from addr 0.
//  2. start; bytes 00 02 | 12 34 56 78 | 9A BC DE F0, in_valid always 1
//     -> im_we@addr0=0x12345678, im_we@addr1=0x9ABCDEF0, then done=1, CpuHold=0.
//  3. Same stream with in_valid toggling every other cycle
//     -> identical writes, no dropped or duplicated bytes, im_we asserted exactly 2x.
//  4. Header 00 00 -> no im_we; done=1 (checksum build: needs CSUM byte 00).
//     ADDR_W=4 with header 00 11 (17 > 16) -> error=1, CpuHold=1, in_ready=0.
//  5. start pulse while in DATA -> ignored, load continues.
//     start while in DONE -> done=0, CpuHold=1, a new load begins.
//  6. LOADER_CHECKSUM_EN, test 2 stream + CSUM byte 0x02
//       (00^02^12^34^56^78^9A^BC^DE^F0) -> done=1.
//     CSUM byte 0x03 -> error=1, CpuHold=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// LOADER_CHECKSUM_EN adds the CSUM state to loader_state_t.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Largest legal word count for a memory of 2**addr_w words.
    function automatic logic [16:0] word_limit(input int addr_w);
        return 17'(1) << addr_w;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes MSB first into 32-bit words and flags each completed word
// for exactly one cycle. Cleared by i_clear when a new load starts.
module byte_packer
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_byte_cnt,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_shift;
    logic        r_word_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
        end else if (i_clear) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_accept && (r_cnt == 2'(WORD_BYTES - 1));
            if (i_accept) begin
                r_cnt   <= r_cnt + 2'd1;
                r_shift <= {r_shift[23:0], i_byte};
            end
        end
    end

    assign o_byte_cnt   = r_cnt;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_shift;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header + big-endian words into instruction memory, holding the
// CPU in reset until loaded. Define LOADER_CHECKSUM_EN for the trailing XOR checksum byte.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              CpuHold,
    output logic              done,
    output logic              error
);

    localparam int            LEN_W = 8 * LEN_BYTES;
    localparam logic [16:0]   LIMIT = word_limit(ADDR_W);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t S_AFTER_PAYLOAD = S_CSUM;
`else
    localparam loader_state_t S_AFTER_PAYLOAD = S_DONE;
`endif

    loader_state_t     r_state, w_next;
    logic              r_in_ready, w_ready_next;
    logic [LEN_W-1:0]  r_len;
    logic [16:0]       r_word_cnt;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_xfer, w_start_ok, w_pk_accept, w_last_word, w_last_byte;
    logic [LEN_W-1:0]  w_len;
    logic [1:0]        w_pk_cnt;
    logic              w_word_valid;
    logic [31:0]       w_word;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_len       = {r_len[15:8], in_data};
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_pk_accept = w_xfer && (r_state == S_DATA);
    assign w_last_word = (r_word_cnt == ({1'b0, r_len} - 17'd1));
    // The final payload byte drops in_ready at once so no byte past the image is consumed.
    assign w_last_byte = w_pk_accept && (w_pk_cnt == 2'(WORD_BYTES - 1)) && w_last_word;

    byte_packer u_packer (
        .i_clk        (Clk),
        .i_rst_n      (Reset),
        .i_clear      (w_start_ok),
        .i_accept     (w_pk_accept),
        .i_byte       (in_data),
        .o_byte_cnt   (w_pk_cnt),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_next       = r_state;
        w_ready_next = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_HI;
            S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == '0)                 w_next = S_AFTER_PAYLOAD;
                    else if ({1'b0, w_len} > LIMIT)  w_next = S_ERR;
                    else                             w_next = S_DATA;
                end
            end
            S_DATA: if (w_word_valid && w_last_word) w_next = S_AFTER_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: if (w_xfer) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
`endif
            default: w_next = S_IDLE;
        endcase

        case (w_next)
`ifdef LOADER_CHECKSUM_EN
            S_CSUM,
`endif
            S_LEN_HI, S_LEN_LO, S_DATA: w_ready_next = 1'b1;
            default:                    w_ready_next = 1'b0;
        endcase
        if (w_last_byte) w_ready_next = 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_ready_next;
            if (w_start_ok) begin
                r_len      <= '0;
                r_word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum     <= '0;
`endif
            end else begin
                if (w_xfer && r_state == S_LEN_HI) r_len[15:8] <= in_data;
                if (w_xfer && r_state == S_LEN_LO) r_len       <= w_len;
                if (w_word_valid) begin
                    r_word_cnt <= r_word_cnt + 17'd1;
                    r_im_addr  <= r_word_cnt[ADDR_W-1:0];
                    r_im_wdata <= w_word;
                end
`ifdef LOADER_CHECKSUM_EN
                if (w_xfer && r_state != S_CSUM) r_csum <= r_csum ^ in_data;
`endif
            end
        end
    end

    // Write port shows the fresh word during the strobe, then holds the last one.
    assign im_we    = w_word_valid;
    assign im_addr  = w_word_valid ? r_word_cnt[ADDR_W-1:0] : r_im_addr;
    assign im_wdata = w_word_valid ? w_word : r_im_wdata;
    assign in_ready = r_in_ready;
    assign CpuHold  = (r_state != S_DONE);
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected IM writes are queued by the stimulus and
// popped by an independent write monitor; a second ADDR_W=4 instance covers the size bound.
module tb_imem_loader;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        start_a, valid_a, start_b, valid_b;
    logic [7:0]  data_a, data_b;
    logic        ready_a, we_a, hold_a, done_a, err_a;
    logic        ready_b, we_b, hold_b, done_b, err_b;
    logic [9:0]  addr_a;
    logic [3:0]  addr_b;
    logic [31:0] wdata_a, wdata_b;

    imem_loader #(.ADDR_W(10)) u_dut (
        .Clk(Clk), .Reset(Reset), .start(start_a), .in_valid(valid_a), .in_data(data_a),
        .in_ready(ready_a), .im_we(we_a), .im_addr(addr_a), .im_wdata(wdata_a),
        .CpuHold(hold_a), .done(done_a), .error(err_a)
    );

    imem_loader #(.ADDR_W(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .start(start_b), .in_valid(valid_b), .in_data(data_b),
        .in_ready(ready_b), .im_we(we_b), .im_addr(addr_b), .im_wdata(wdata_b),
        .CpuHold(hold_b), .done(done_b), .error(err_b)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;
    int  wr_cnt_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Write monitor for the main instance
    always @(negedge Clk) begin
        wr_t e;
        if (we_a === 1'b1) begin
            wr_cnt_a++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%08h, expected no write", addr_a, wdata_a);
            end else begin
                e = exp_q.pop_front();
                $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)", addr_a, wdata_a, e.addr, e.data);
                check("write_addr", 32'(addr_a), 32'(e.addr));
                check("write_data", wdata_a, e.data);
            end
        end
        if (we_b === 1'b1) begin
            n_total++;
            $display("FAIL dut4_unexpected_write: got addr=%0d, expected no write", addr_b);
        end
    end

    task automatic send_byte(input bit sel, input logic [7:0] b, input bit gap);
        int n;
        if (gap) begin
            if (sel) valid_b = 1'b0; else valid_a = 1'b0;
            @(negedge Clk);
        end
        if (sel) begin valid_b = 1'b1; data_b = b; end
        else     begin valid_a = 1'b1; data_a = b; end
        n = 0;
        while (!(sel ? ready_b : ready_a) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL byte_accept_timeout: got in_ready=0 for 100 cycles, expected 1");
        end
        @(negedge Clk);
        if (sel) valid_b = 1'b0; else valid_a = 1'b0;
    endtask

    task automatic send_hdr(input bit sel, input logic [15:0] n, input bit gap);
        send_byte(sel, n[15:8], gap);
        send_byte(sel, n[7:0], gap);
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input bit gap);
        send_byte(sel, w[31:24], gap);
        send_byte(sel, w[23:16], gap);
        send_byte(sel, w[15:8], gap);
        send_byte(sel, w[7:0], gap);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge Clk);
        if (sel) start_b = 1'b0; else start_a = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done_a || err_a) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) begin
            n_total++;
            $display("FAIL end_timeout: got done=0 error=0 after 200 cycles, expected done or error");
        end
    endtask

    task automatic push_exp(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Two-word image 00 02 | 12345678 | 9ABCDEF0 (checksum 0x02 when enabled)
    task automatic load_basic(input bit gap, input string tag);
        int w0;
        w0 = wr_cnt_a;
        pulse_start(1'b0);
        push_exp(10'd0, 32'h12345678);
        push_exp(10'd1, 32'h9ABCDEF0);
        send_hdr(1'b0, 16'h0002, gap);
        send_word(1'b0, 32'h12345678, gap);
        send_word(1'b0, 32'h9ABCDEF0, gap);
`ifdef LOADER_CHECKSUM_EN
        send_byte(1'b0, 8'h02, gap);
`endif
        wait_end();
        check({tag, "_done"}, 32'(done_a), 32'd1);
        check({tag, "_cpuhold"}, 32'(hold_a), 32'd0);
        check({tag, "_error"}, 32'(err_a), 32'd0);
        check({tag, "_in_ready"}, 32'(ready_a), 32'd0);
        check({tag, "_write_count"}, 32'(wr_cnt_a - w0), 32'd2);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_addr_hold"}, 32'(addr_a), 32'd1);
        check({tag, "_wdata_hold"}, wdata_a, 32'h9ABCDEF0);
    endtask

    initial begin
        int w0;
        Reset = 1'b0;
        start_a = 1'b0; valid_a = 1'b0; data_a = 8'h00;
        start_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;
        repeat (3) @(negedge Clk);
        check("reset_cpuhold", 32'(hold_a), 32'd1);
        check("reset_in_ready", 32'(ready_a), 32'd0);
        check("reset_im_we", 32'(we_a), 32'd0);
        check("reset_done", 32'(done_a), 32'd0);
        check("reset_error", 32'(err_a), 32'd0);
        check("reset_im_addr", 32'(addr_a), 32'd0);
        check("reset_im_wdata", wdata_a, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // Reset in the middle of DATA after six bytes
        pulse_start(1'b0);
        push_exp(10'd0, 32'h12345678);
        send_hdr(1'b0, 16'h0002, 1'b0);
        send_word(1'b0, 32'h12345678, 1'b0);
        @(negedge Clk);
        check("midload_writes", 32'(wr_cnt_a), 32'd1);
        Reset = 1'b0;
        @(negedge Clk);
        check("midreset_cpuhold", 32'(hold_a), 32'd1);
        check("midreset_in_ready", 32'(ready_a), 32'd0);
        check("midreset_im_we", 32'(we_a), 32'd0);
        check("midreset_done", 32'(done_a), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        load_basic(1'b0, "stream");
        load_basic(1'b1, "toggle");

        // Empty image
        w0 = wr_cnt_a;
        pulse_start(1'b0);
        send_hdr(1'b0, 16'h0000, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(1'b0, 8'h00, 1'b0);
`endif
        wait_end();
        check("empty_done", 32'(done_a), 32'd1);
        check("empty_cpuhold", 32'(hold_a), 32'd0);
        check("empty_writes", 32'(wr_cnt_a - w0), 32'd0);

        // Size bound on a 16-word memory: 17 rejected, 16 accepted
        pulse_start(1'b1);
        send_hdr(1'b1, 16'h0011, 1'b0);
        repeat (2) @(negedge Clk);
        check("oversize_error", 32'(err_b), 32'd1);
        check("oversize_cpuhold", 32'(hold_b), 32'd1);
        check("oversize_in_ready", 32'(ready_b), 32'd0);
        check("oversize_done", 32'(done_b), 32'd0);
        pulse_start(1'b1);
        check("restart_from_err_error", 32'(err_b), 32'd0);
        send_hdr(1'b1, 16'h0010, 1'b0);
        @(negedge Clk);
        check("fullsize_error", 32'(err_b), 32'd0);
        check("fullsize_in_ready", 32'(ready_b), 32'd1);

        // start during DATA is ignored
        w0 = wr_cnt_a;
        pulse_start(1'b0);
        push_exp(10'd0, 32'h12345678);
        push_exp(10'd1, 32'h9ABCDEF0);
        send_hdr(1'b0, 16'h0002, 1'b0);
        send_byte(1'b0, 8'h12, 1'b0);
        send_byte(1'b0, 8'h34, 1'b0);
        pulse_start(1'b0);
        send_byte(1'b0, 8'h56, 1'b0);
        send_byte(1'b0, 8'h78, 1'b0);
        send_word(1'b0, 32'h9ABCDEF0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(1'b0, 8'h02, 1'b0);
`endif
        wait_end();
        check("start_in_data_done", 32'(done_a), 32'd1);
        check("start_in_data_writes", 32'(wr_cnt_a - w0), 32'd2);

        // start during DONE begins a new load
        pulse_start(1'b0);
        check("restart_done", 32'(done_a), 32'd0);
        check("restart_cpuhold", 32'(hold_a), 32'd1);
        check("restart_in_ready", 32'(ready_a), 32'd1);
        w0 = wr_cnt_a;
        push_exp(10'd0, 32'hDEADBEEF);
        send_hdr(1'b0, 16'h0001, 1'b0);
        send_word(1'b0, 32'hDEADBEEF, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(1'b0, 8'h23, 1'b0);
`endif
        wait_end();
        check("reload_done", 32'(done_a), 32'd1);
        check("reload_writes", 32'(wr_cnt_a - w0), 32'd1);
        check("reload_addr_hold", 32'(addr_a), 32'd0);
        check("reload_wdata_hold", wdata_a, 32'hDEADBEEF);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: words written, then error with CPU still held
        w0 = wr_cnt_a;
        pulse_start(1'b0);
        push_exp(10'd0, 32'h12345678);
        push_exp(10'd1, 32'h9ABCDEF0);
        send_hdr(1'b0, 16'h0002, 1'b0);
        send_word(1'b0, 32'h12345678, 1'b0);
        send_word(1'b0, 32'h9ABCDEF0, 1'b0);
        send_byte(1'b0, 8'h03, 1'b0);
        wait_end();
        check("badcsum_error", 32'(err_a), 32'd1);
        check("badcsum_cpuhold", 32'(hold_a), 32'd1);
        check("badcsum_done", 32'(done_a), 32'd0);
        check("badcsum_writes", 32'(wr_cnt_a - w0), 32'd2);
`endif

        repeat (3) @(negedge Clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
